pc_fetch_ctrl: RTL and testbench

- Fetch-side controller on the read side of the 32-bit PC register.
- Each fetch cycle it:
  - samples the current PC,
  - fetches one instruction from instruction memory over a req/ack handshake,
  - presents the instruction downstream,
  - drives the PC register's data_in/ena with the next PC (sequential +4 or branch target).

---
 rtl/pc_fetch_ctrl_if.sv | 22 ++
 rtl/pc_fetch_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory fetch bus: req/addr from the fetch controller, ack/rdata
// from memory. rdata is valid in the same cycle as ack.
interface pc_fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch-side controller: samples the PC, fetches one instruction over req/ack,
// delivers it downstream and writes the next PC (sequential or branch target).
module pc_fetch_ctrl #(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  input  logic                   stall,
  input  logic [31:0]            pc_in,
  input  logic                   branch_valid,
  input  logic [31:0]            branch_target,
  pc_fetch_ctrl_if.master        imem,
  output logic [31:0]            instr_out,
  output logic                   instr_valid,
  output logic [31:0]            pc_next,
  output logic                   pc_ena,
  output logic                   err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    UPDATE = 2'd2,
    ERR    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic        ivalid_q, ivalid_d;
  logic [31:0] pcnext_q, pcnext_d;
  logic        pcena_q, pcena_d;
  logic        err_q, err_d;
  logic        pend_q, pend_d;
  logic        flush_q, flush_d;
  logic [31:0] tgt_q, tgt_d;
  logic [7:0]  wait_q, wait_d;

  // A branch arriving in the ack cycle must already steer this completion.
  logic        br_pend;
  logic [31:0] br_tgt;
  logic        flushed;

  assign br_pend = pend_q | branch_valid;
  assign br_tgt  = branch_valid ? branch_target : tgt_q;
  assign flushed = flush_q | branch_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      addr_q   <= '0;
      instr_q  <= '0;
      ivalid_q <= 1'b0;
      pcnext_q <= '0;
      pcena_q  <= 1'b0;
      err_q    <= 1'b0;
      pend_q   <= 1'b0;
      flush_q  <= 1'b0;
      tgt_q    <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      instr_q  <= instr_d;
      ivalid_q <= ivalid_d;
      pcnext_q <= pcnext_d;
      pcena_q  <= pcena_d;
      err_q    <= err_d;
      pend_q   <= pend_d;
      flush_q  <= flush_d;
      tgt_q    <= tgt_d;
      wait_q   <= wait_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    addr_d   = addr_q;
    instr_d  = instr_q;
    ivalid_d = 1'b0;
    pcnext_d = pcnext_q;
    pcena_d  = 1'b0;
    err_d    = err_q;
    pend_d   = pend_q;
    flush_d  = flush_q;
    tgt_d    = tgt_q;
    wait_d   = wait_q;

    if (state_q != ERR && branch_valid) begin
      pend_d = 1'b1;
      tgt_d  = branch_target;
    end

    case (state_q)
      IDLE: begin
        if (run && !stall) begin
          if (pc_in[1:0] == 2'b00) begin
            state_d = FETCH;
            addr_d  = pc_in;
            req_d   = 1'b1;
            wait_d  = '0;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
      end

      FETCH: begin
        if (branch_valid) begin
          flush_d = 1'b1;
        end
        if (imem.imem_ack) begin
          req_d = 1'b0;
          if (!flushed) begin
            instr_d  = imem.imem_rdata;
            ivalid_d = 1'b1;
          end
          pcnext_d = br_pend ? br_tgt : addr_q + 32'(PC_STEP);
          pcena_d  = 1'b1;
          state_d  = UPDATE;
        end else if (wait_q == 8'(MAX_WAIT - 1)) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      UPDATE: begin
        // The previous pending branch was consumed at ack; only a new pulse survives.
        pend_d  = branch_valid;
        flush_d = 1'b0;
        state_d = IDLE;
      end

      ERR: begin
        req_d = 1'b0;
        err_d = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;
  assign instr_out      = instr_q;
  assign instr_valid    = ivalid_q;
  assign pc_next        = pcnext_q;
  assign pc_ena         = pcena_q;
  assign err            = err_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: hand-computed expectations sampled on the
// falling clock edge, with the memory and PC inputs driven from the stimulus.
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        stall;
  logic [31:0] pc_in;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic [31:0] pc_next;
  logic        pc_ena;
  logic        err;

  int unsigned n_chk;
  int unsigned n_err;

  pc_fetch_ctrl_if bus ();

  pc_fetch_ctrl #(
    .MAX_WAIT (15),
    .PC_STEP  (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .run           (run),
    .stall         (stall),
    .pc_in         (pc_in),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .imem          (bus),
    .instr_out     (instr_out),
    .instr_valid   (instr_valid),
    .pc_next       (pc_next),
    .pc_ena        (pc_ena),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    run = 1'b0;
    stall = 1'b0;
    pc_in = '0;
    branch_valid = 1'b0;
    branch_target = '0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req",   32'(bus.imem_req), 32'd0);
    check("rst_addr",  bus.imem_addr, 32'd0);
    check("rst_instr", instr_out, 32'd0);
    check("rst_vld",   32'(instr_valid), 32'd0);
    check("rst_pcnext", pc_next, 32'd0);
    check("rst_pcena", 32'(pc_ena), 32'd0);
    check("rst_err",   32'(err), 32'd0);

    // Zero-wait fetches, 3 cycles per instruction
    rst_n = 1'b1; run = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = 32'h2001_0005; pc_in = 32'h0;
    @(negedge clk);
    check("t1_req",  32'(bus.imem_req), 32'd1);
    check("t1_addr", bus.imem_addr, 32'h0);
    check("t1_vld_early", 32'(instr_valid), 32'd0);
    @(negedge clk);
    check("t1_req_drop", 32'(bus.imem_req), 32'd0);
    check("t1_vld",    32'(instr_valid), 32'd1);
    check("t1_instr",  instr_out, 32'h2001_0005);
    check("t1_pcnext", pc_next, 32'h0000_0004);
    check("t1_pcena",  32'(pc_ena), 32'd1);
    pc_in = 32'h4;
    @(negedge clk);
    check("t1_upd_vld", 32'(instr_valid), 32'd0);
    check("t1_upd_ena", 32'(pc_ena), 32'd0);
    check("t1_upd_req", 32'(bus.imem_req), 32'd0);
    @(negedge clk);
    check("t1_req2",  32'(bus.imem_req), 32'd1);
    check("t1_addr2", bus.imem_addr, 32'h4);
    @(negedge clk);
    check("t1_vld2",    32'(instr_valid), 32'd1);
    check("t1_pcnext2", pc_next, 32'h8);
    run = 1'b0; bus.imem_ack = 1'b0;
    @(negedge clk);

    // Ack delayed: req held 6 cycles with stable address; run drop does not abort
    pc_in = 32'h20; run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t2_req_hold",  32'(bus.imem_req), 32'd1);
      check("t2_addr_hold", bus.imem_addr, 32'h20);
      if (i == 0) run = 1'b0;
      if (i == 5) begin
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'hA5A5_0001;
      end
    end
    @(negedge clk);
    check("t2_req_drop", 32'(bus.imem_req), 32'd0);
    check("t2_vld",    32'(instr_valid), 32'd1);
    check("t2_instr",  instr_out, 32'hA5A5_0001);
    check("t2_pcnext", pc_next, 32'h24);
    check("t2_err",    32'(err), 32'd0);
    bus.imem_ack = 1'b0;
    @(negedge clk);

    // Branch in the ack cycle flushes the in-flight instruction
    pc_in = 32'h40; run = 1'b1;
    @(negedge clk);
    check("t3_addr", bus.imem_addr, 32'h40);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    branch_valid = 1'b1; branch_target = 32'h100; run = 1'b0;
    @(negedge clk);
    check("t3_vld_flush", 32'(instr_valid), 32'd0);
    check("t3_instr_keep", instr_out, 32'hA5A5_0001);
    check("t3_pcnext", pc_next, 32'h100);
    check("t3_pcena",  32'(pc_ena), 32'd1);
    bus.imem_ack = 1'b0; branch_valid = 1'b0; pc_in = 32'h100;
    @(negedge clk);
    run = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0000_0013;
    @(negedge clk);
    check("t3_addr_tgt", bus.imem_addr, 32'h100);
    run = 1'b0;
    @(negedge clk);
    check("t3_vld_after", 32'(instr_valid), 32'd1);
    check("t3_instr_after", instr_out, 32'h13);
    check("t3_pcnext_after", pc_next, 32'h104);
    bus.imem_ack = 1'b0;
    @(negedge clk);

    // Branch in IDLE stays pending and steers the next fetch's pc_next
    branch_valid = 1'b1; branch_target = 32'h200; pc_in = 32'h80;
    @(negedge clk);
    branch_valid = 1'b0; branch_target = 32'hFFFF_0000;
    run = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = 32'h33;
    @(negedge clk);
    check("t4_addr", bus.imem_addr, 32'h80);
    run = 1'b0;
    @(negedge clk);
    check("t4_vld",    32'(instr_valid), 32'd1);
    check("t4_instr",  instr_out, 32'h33);
    check("t4_pcnext", pc_next, 32'h200);
    bus.imem_ack = 1'b0;
    @(negedge clk);

    // Sequential PC wraps modulo 2^32
    pc_in = 32'hFFFF_FFFC; run = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = 32'h44;
    @(negedge clk);
    check("t5_addr", bus.imem_addr, 32'hFFFF_FFFC);
    run = 1'b0;
    @(negedge clk);
    check("t5_pcnext", pc_next, 32'h0);
    check("t5_pcena",  32'(pc_ena), 32'd1);
    bus.imem_ack = 1'b0;
    @(negedge clk);

    // Stall holds off the request, then an unacknowledged fetch times out
    pc_in = 32'h8; run = 1'b1; stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6_stall_req", 32'(bus.imem_req), 32'd0);
    end
    stall = 1'b0;
    @(negedge clk);
    check("t6_req_start", 32'(bus.imem_req), 32'd1);
    check("t6_addr", bus.imem_addr, 32'h8);
    for (int i = 2; i <= 15; i++) begin
      @(negedge clk);
      check("t6_req_wait", 32'(bus.imem_req), 32'd1);
    end
    @(negedge clk);
    check("t6_req_timeout", 32'(bus.imem_req), 32'd0);
    check("t6_err", 32'(err), 32'd1);
    bus.imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_err_hold", 32'(err), 32'd1);
      check("t6_err_req",  32'(bus.imem_req), 32'd0);
      check("t6_err_vld",  32'(instr_valid), 32'd0);
      check("t6_err_ena",  32'(pc_ena), 32'd0);
    end

    // Asynchronous reset clears the sticky error between edges
    #2 rst_n = 1'b0;
    #1 check("t7_async_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; run = 1'b1; bus.imem_ack = 1'b0; pc_in = 32'h6;

    // Misaligned PC goes straight to ERR without a request
    @(negedge clk);
    check("t8_err", 32'(err), 32'd1);
    check("t8_req", 32'(bus.imem_req), 32'd0);
    pc_in = 32'h0; bus.imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t8_err_hold", 32'(err), 32'd1);
      check("t8_req_hold", 32'(bus.imem_req), 32'd0);
    end
    #2 rst_n = 1'b0;
    #1 check("t8_async_err", 32'(err), 32'd0);
    @(negedge clk);

    // Asynchronous reset mid-FETCH drops imem_req immediately
    rst_n = 1'b1; run = 1'b1; bus.imem_ack = 1'b0; pc_in = 32'hC;
    @(negedge clk);
    check("t9_req", 32'(bus.imem_req), 32'd1);
    check("t9_addr", bus.imem_addr, 32'hC);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t9_async_req",  32'(bus.imem_req), 32'd0);
    check("t9_async_addr", bus.imem_addr, 32'd0);
    check("t9_async_err",  32'(err), 32'd0);
    @(negedge clk);
    check("t9_rst_req", 32'(bus.imem_req), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
